// File: rtl/prg_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : prg_monitor_if
// Description : Host byte link and programmer memory port bundle for
//               prg_monitor. The master modport is the monitor side, the
//               slave modport is the UART/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface prg_monitor_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       prg_we;
    logic [7:0] prg_MA;
    logic [7:0] prg_WD;
    logic [7:0] prg_RD;
    logic       busy;
    logic       rx_drop;

    modport master (
        input  rx_data, rx_valid, tx_ready, prg_RD,
        output tx_data, tx_valid, prg_we, prg_MA, prg_WD, busy, rx_drop
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, prg_RD,
        input  tx_data, tx_valid, prg_we, prg_MA, prg_WD, busy, rx_drop
    );
endinterface
`default_nettype wire

// File: rtl/prg_monitor.sv
`default_nettype none
// ============================================================================
// Module      : prg_monitor
// Description : Byte-command engine driving the CDECv programmer memory port.
//               Commands: 'W' addr data (write, ACK), 'R' addr (read),
//               'D' addr cnt (burst dump, cnt=0 -> 256, address wraps).
//               Unknown opcodes answer NAK.
//               Optional inter-byte timeout: define PRG_MONITOR_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prg_monitor #(
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic        clock,
    input  wire logic        reset,
    prg_monitor_if.master    bus
);

    localparam logic [7:0] c_OP_WRITE = 8'h57;
    localparam logic [7:0] c_OP_READ  = 8'h52;
    localparam logic [7:0] c_OP_DUMP  = 8'h44;
    localparam logic [7:0] c_OP_NONE  = 8'h00;
    localparam logic [7:0] c_ACK      = 8'h06;
    localparam logic [7:0] c_NAK      = 8'h15;
    localparam logic [1:0] c_WAIT_LAST = 2'(RD_LATENCY);

    // Elaboration-time guard on the configuration range
    if (RD_LATENCY < 1 || RD_LATENCY > 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("prg_monitor: RD_LATENCY must be 1..3 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_GET_CNT  = 3'd3,
        S_WRITE    = 3'd4,
        S_RD_WAIT  = 3'd5,
        S_SEND     = 3'd6
    } state_t;

    state_t     r_state;
    logic [7:0] r_opcode;
    logic [8:0] r_count;
    logic [1:0] r_wait;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       r_prg_we;
    logic [7:0] r_prg_ma;
    logic [7:0] r_prg_wd;
    logic       r_busy;
    logic       r_rx_drop;
    logic       w_timeout;

`ifdef PRG_MONITOR_TIMEOUT_EN
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_timer;
    logic        w_arg_state;

    assign w_arg_state = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA) ||
                         (r_state == S_GET_CNT);
    assign w_timeout   = w_arg_state && (r_timer == c_TIMEOUT_LAST);

    // Cycles since the last accepted byte while waiting for a command argument
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_arg_state && !bus.rx_valid && !w_timeout) begin
            r_timer <= r_timer + 32'd1;
        end else begin
            r_timer <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Command FSM; every output is a register updated here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_opcode   <= '0;
            r_count    <= '0;
            r_wait     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_prg_we   <= 1'b0;
            r_prg_ma   <= '0;
            r_prg_wd   <= '0;
            r_busy     <= 1'b0;
            r_rx_drop  <= 1'b0;
        end else begin
            r_prg_we  <= 1'b0;
            // Bytes arriving while the FSM is busy internally are lost
            r_rx_drop <= bus.rx_valid && ((r_state == S_WRITE) ||
                         (r_state == S_RD_WAIT) || (r_state == S_SEND));
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        r_opcode <= bus.rx_data;
                        r_busy   <= 1'b1;
                        if (bus.rx_data == c_OP_WRITE || bus.rx_data == c_OP_READ ||
                            bus.rx_data == c_OP_DUMP) begin
                            r_state <= S_GET_ADDR;
                        end else begin
                            r_tx_data  <= c_NAK;
                            r_tx_valid <= 1'b1;
                            r_state    <= S_SEND;
                        end
                    end
                end
                S_GET_ADDR, S_GET_DATA, S_GET_CNT: begin
                    if (bus.rx_valid) begin
                        r_wait <= '0;
                        if (r_state == S_GET_ADDR) begin
                            r_prg_ma <= bus.rx_data;
                            if (r_opcode == c_OP_WRITE)     r_state <= S_GET_DATA;
                            else if (r_opcode == c_OP_DUMP) r_state <= S_GET_CNT;
                            else                            r_state <= S_RD_WAIT;
                        end else if (r_state == S_GET_DATA) begin
                            r_prg_wd <= bus.rx_data;
                            r_prg_we <= 1'b1;
                            r_state  <= S_WRITE;
                        end else begin
                            r_count <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                            r_state <= S_RD_WAIT;
                        end
                    end else if (w_timeout) begin
                        // Abandoned command: answer NAK and make SEND return to IDLE
                        r_opcode   <= c_OP_NONE;
                        r_tx_data  <= c_NAK;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_WRITE: begin
                    r_tx_data  <= c_ACK;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_RD_WAIT: begin
                    if (r_wait == c_WAIT_LAST) begin
                        r_tx_data  <= bus.prg_RD;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                S_SEND: begin
                    if (r_tx_valid && bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_opcode == c_OP_DUMP && r_count > 9'd1) begin
                            r_count  <= r_count - 9'd1;
                            r_prg_ma <= r_prg_ma + 8'd1;
                            r_wait   <= '0;
                            r_state  <= S_RD_WAIT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.prg_we   = r_prg_we;
    assign bus.prg_MA   = r_prg_ma;
    assign bus.prg_WD   = r_prg_wd;
    assign bus.busy     = r_busy;
    assign bus.rx_drop  = r_rx_drop;

endmodule
`default_nettype wire

// File: tb/tb_prg_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_prg_monitor
// Description : Self-checking bench for prg_monitor with a latency-accurate
//               memory model and a reference memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prg_monitor;
    localparam int LAT = 2;
    localparam int TO  = 50;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    prg_monitor_if bus();

    prg_monitor #(.RD_LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous memory: prg_RD valid LAT cycles after prg_MA changes
    logic [7:0] mem [256];
    logic [7:0] pipe [LAT];
    logic       bd_en = 1'b0;
    logic [7:0] bd_addr = '0;
    logic [7:0] bd_data = '0;
    always @(posedge clock) begin
        pipe[0] <= mem[bus.prg_MA];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        if (bd_en)                    mem[bd_addr]    <= bd_data;
        else if (bus.prg_we === 1'b1) mem[bus.prg_MA] <= bus.prg_WD;
    end
    assign bus.prg_RD = pipe[LAT-1];

    int we_count = 0;
    always @(posedge clock) if (bus.prg_we === 1'b1) we_count <= we_count + 1;

    logic [7:0] ref_mem [256];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    // Waits (bounded) for tx_valid; consumes the byte if tx_ready is high
    task automatic recv(input string tag, input int budget, output logic [7:0] d,
                        output int c, output logic [7:0] ma);
        c = 0;
        while (bus.tx_valid !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_tx_valid"}, bus.tx_valid, 1);
        d  = bus.tx_data;
        ma = bus.prg_MA;
        if (bus.tx_ready === 1'b1) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_valid"}, bus.tx_valid, 0);
        check({tag, "_tx_data"},  bus.tx_data,  0);
        check({tag, "_prg_we"},   bus.prg_we,   0);
        check({tag, "_prg_MA"},   bus.prg_MA,   0);
        check({tag, "_prg_WD"},   bus.prg_WD,   0);
        check({tag, "_busy"},     bus.busy,     0);
        check({tag, "_rx_drop"},  bus.rx_drop,  0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] v);
        logic [7:0] d, ma;
        int c, w0;
        send_byte(8'h57);
        send_byte(a);
        w0 = we_count;
        send_byte(v);
        check("wr_we",  bus.prg_we, 1);
        check("wr_MA",  bus.prg_MA, a);
        check("wr_WD",  bus.prg_WD, v);
        ref_mem[a] = v;
        recv("wr", 20, d, c, ma);
        check("wr_ack", d, 8'h06);
        check("wr_pulses", we_count - w0, 1);
        check("wr_busy_end", bus.busy, 0);
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [7:0] d, ma;
        int c;
        send_byte(8'h52);
        send_byte(a);
        recv("rd", 20, d, c, ma);
        check("rd_data", d, ref_mem[a]);
        check("rd_latency", c, LAT + 1);
        check("rd_busy_end", bus.busy, 0);
        check("rd_tx_valid_end", bus.tx_valid, 0);
    endtask

    task automatic do_dump(input logic [7:0] a, input logic [7:0] cnt);
        logic [7:0] d, ma, exp_a;
        int c, n;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        send_byte(8'h44);
        send_byte(a);
        send_byte(cnt);
        for (int k = 0; k < n; k++) begin
            exp_a = 8'((int'(a) + k) % 256);
            recv("dump", 20, d, c, ma);
            check("dump_data", d, ref_mem[exp_a]);
            check("dump_MA", ma, exp_a);
            check("dump_latency", c, LAT + 1);
            if (k < n - 1) check("dump_busy_mid", bus.busy, 1);
        end
        check("dump_busy_end", bus.busy, 0);
        check("dump_tx_valid_end", bus.tx_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, d0, ma, a, op;
        int c, drops, w0;
        logic stable;

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        // Backdoor preload of the memory and its reference image
        for (int i = 0; i < 256; i++) begin
            bd_en   = 1'b1;
            bd_addr = 8'(i);
            bd_data = 8'($urandom);
            ref_mem[i] = bd_data;
            tick();
        end
        bd_en = 1'b0;
        tick();

        // Directed write then read-back
        do_write(8'h10, 8'hA5);
        do_read(8'h10);

        // Random writes and reads
        for (int i = 0; i < 6; i++) begin
            do_write(8'($urandom), 8'($urandom));
            do_read(8'($urandom));
        end

        // Dump across the FF->00 wrap
        do_write(8'hFE, 8'h11);
        do_write(8'hFF, 8'h22);
        do_write(8'h00, 8'h33);
        do_write(8'h01, 8'h44);
        do_dump(8'hFE, 8'h04);

        // Random short dumps and a full 256-byte dump
        do_dump(8'($urandom), 8'($urandom_range(1, 9)));
        do_dump(8'($urandom), 8'($urandom_range(1, 9)));
        do_dump(8'($urandom), 8'h00);

        // Back-pressure with a dropped rx byte
        a = 8'($urandom);
        bus.tx_ready = 1'b0;
        send_byte(8'h52);
        send_byte(a);
        recv("bp", 20, d0, c, ma);
        check("bp_latency", c, LAT + 1);
        stable = 1'b1;
        drops  = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                bus.rx_data  = 8'($urandom);
                bus.rx_valid = 1'b1;
            end
            tick();
            bus.rx_valid = 1'b0;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== d0) stable = 1'b0;
            if (bus.rx_drop === 1'b1) drops++;
        end
        check("bp_stable", stable, 1);
        check("bp_drops", drops, 1);
        check("bp_data", d0, ref_mem[a]);
        bus.tx_ready = 1'b1;
        tick();
        check("bp_tx_valid_end", bus.tx_valid, 0);
        check("bp_busy_end", bus.busy, 0);

        // Bad opcodes
        send_byte(8'h7A);
        recv("nak", 20, d, c, ma);
        check("nak_7A", d, 8'h15);
        check("nak_busy_end", bus.busy, 0);
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52 || op == 8'h44);
        send_byte(op);
        recv("nak_rand", 20, d, c, ma);
        check("nak_rand", d, 8'h15);

        // Reset in the middle of a write command
        w0 = we_count;
        send_byte(8'h57);
        send_byte(8'h20);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midrst_no_write", we_count - w0, 0);
        do_read(8'h20);

`ifdef PRG_MONITOR_TIMEOUT_EN
        // Abandoned command times out with NAK
        send_byte(8'h52);
        recv("timeout", 200, d, c, ma);
        check("timeout_nak", d, 8'h15);
        check("timeout_cycles", c, TO);
        check("timeout_busy_end", bus.busy, 0);
        do_read(8'($urandom));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
